game_state_ctrl: RTL and testbench

GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

---
 rtl/game_pkg.sv | 31 +++
 rtl/vga_pkg.sv | 7 +
 rtl/edge_detect.sv | 31 +++
 rtl/game_state_ctrl.sv | 135 +++++++++++++
 tb/tb_game_state_ctrl.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - game state encoding, hold length and start-button geometry
package game_pkg;

   import vga_pkg::*;

   typedef enum logic [1:0] {
      SELECT = 2'd0,
      PLAY   = 2'd1,
      WIN    = 2'd2,
      LOSE   = 2'd3
   } game_state_t;

   localparam int              HOLD_W      = 8;
   localparam logic [HOLD_W-1:0] HOLD_FRAMES = 8'd180;

   // Start button is centred on screen: a quarter of the width, a twelfth of the height.
   localparam int START_W = HOR_PIXELS / 4;
   localparam int START_H = VER_PIXELS / 12;
   localparam int START_X = (HOR_PIXELS - START_W) / 2;
   localparam int START_Y = (VER_PIXELS - START_H) / 2;

   localparam logic [11:0] START_X_LO = 12'(START_X);
   localparam logic [11:0] START_X_HI = 12'(START_X + START_W);
   localparam logic [11:0] START_Y_LO = 12'(START_Y);
   localparam logic [11:0] START_Y_HI = 12'(START_Y + START_H);

   function automatic logic in_start_button(input logic [11:0] x, input logic [11:0] y);
      return (x >= START_X_LO) && (x < START_X_HI) && (y >= START_Y_LO) && (y < START_Y_HI);
   endfunction

endpackage

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - VGA screen geometry shared by the display and game logic
package vga_pkg;

   localparam int HOR_PIXELS = 800;
   localparam int VER_PIXELS = 600;

endpackage

// File: rtl/edge_detect.sv
// rtl/edge_detect.sv - registered rising-edge detector with one-cycle pulse
module edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise
);

   logic q;
   logic hist;
   logic valid;
   logic armed;

   // armed only after a genuine low has been seen, so a level already high at reset gives no pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         q     <= 1'b0;
         hist  <= 1'b0;
         valid <= 1'b0;
         armed <= 1'b0;
      end else begin
         q     <= d;
         hist  <= q;
         valid <= 1'b1;
         armed <= armed | (valid & ~q);
      end
   end

   assign rise = q & ~hist & armed;

endmodule

// File: rtl/game_state_ctrl.sv
// rtl/game_state_ctrl.sv - frame-synchronous game state machine with end-of-game hold timer
module game_state_ctrl
   import game_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] mouse_x,
   input  logic [11:0] mouse_y,
   input  logic        mouse_clicked,
   input  logic [1:0]  char_class,
   input  logic        player_dead,
   input  logic        boss_dead,
   input  logic        vblnk,
   output logic [1:0]  game_active,
   output logic        restart,
   output logic        frame_tick,
   output logic        hold_active
);

   logic [11:0] x_s1, y_s1;
   logic [1:0]  class_s1;
   logic        pdead_s1, bdead_s1;
   logic        click_edge;

   game_state_t       state, state_nxt;
   logic [HOLD_W-1:0] hold_cnt, hold_nxt;
   logic              start_pend, lose_pend, win_pend, ret_pend;
   logic              start_pend_nxt, lose_pend_nxt, win_pend_nxt, ret_pend_nxt;
   logic              restart_nxt;
   logic              click_ok, start_set, lose_set, win_set, ret_set;
   logic              start_eff, lose_eff, win_eff, ret_eff;

   always_ff @(posedge clk) begin
      if (rst) begin
         x_s1     <= '0;
         y_s1     <= '0;
         class_s1 <= '0;
         pdead_s1 <= 1'b0;
         bdead_s1 <= 1'b0;
      end else begin
         x_s1     <= mouse_x;
         y_s1     <= mouse_y;
         class_s1 <= char_class;
         pdead_s1 <= player_dead;
         bdead_s1 <= boss_dead;
      end
   end

   edge_detect u_click_edge (
      .clk  (clk),
      .rst  (rst),
      .d    (mouse_clicked),
      .rise (click_edge)
   );

   edge_detect u_vblnk_edge (
      .clk  (clk),
      .rst  (rst),
      .d    (vblnk),
      .rise (frame_tick)
   );

   assign hold_active = (hold_cnt != '0);
   assign game_active = state;

   always_comb begin
      state_nxt   = state;
      hold_nxt    = hold_cnt;
      restart_nxt = 1'b0;

      click_ok  = click_edge & ~hold_active;
      start_set = (state == SELECT) & click_ok & in_start_button(x_s1, y_s1) & (class_s1 != 2'd0);
      // a death arriving after the opposite outcome is already pending is dropped
      lose_set  = (state == PLAY) & pdead_s1 & ~win_pend;
      win_set   = (state == PLAY) & bdead_s1 & ~lose_pend;
      ret_set   = ((state == WIN) | (state == LOSE)) & click_ok;

      start_eff = start_pend | start_set;
      lose_eff  = lose_pend  | lose_set;
      win_eff   = win_pend   | win_set;
      ret_eff   = ret_pend   | ret_set;

      if (frame_tick) begin
         unique case (state)
            SELECT: if (start_eff) state_nxt = PLAY;
            PLAY: begin
               if (lose_eff)      state_nxt = LOSE;
               else if (win_eff)  state_nxt = WIN;
            end
            WIN, LOSE: begin
               if (ret_eff) begin
                  state_nxt   = SELECT;
                  restart_nxt = 1'b1;
               end
            end
         endcase

         if (hold_cnt != '0) hold_nxt = hold_cnt - 1'b1;
         if ((state == PLAY) && (state_nxt != PLAY)) hold_nxt = HOLD_FRAMES;
      end

      if (state_nxt != state) begin
         start_pend_nxt = 1'b0;
         lose_pend_nxt  = 1'b0;
         win_pend_nxt   = 1'b0;
         ret_pend_nxt   = 1'b0;
      end else begin
         start_pend_nxt = start_eff;
         lose_pend_nxt  = lose_eff;
         win_pend_nxt   = win_eff;
         ret_pend_nxt   = ret_eff;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= SELECT;
         hold_cnt   <= '0;
         start_pend <= 1'b0;
         lose_pend  <= 1'b0;
         win_pend   <= 1'b0;
         ret_pend   <= 1'b0;
         restart    <= 1'b0;
      end else begin
         state      <= state_nxt;
         hold_cnt   <= hold_nxt;
         start_pend <= start_pend_nxt;
         lose_pend  <= lose_pend_nxt;
         win_pend   <= win_pend_nxt;
         ret_pend   <= ret_pend_nxt;
         restart    <= restart_nxt;
      end
   end

endmodule

// File: tb/tb_game_state_ctrl.sv
// tb/tb_game_state_ctrl.sv - directed self-checking bench for game_state_ctrl
module tb_game_state_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] mouse_x, mouse_y;
   logic        mouse_clicked;
   logic [1:0]  char_class;
   logic        player_dead, boss_dead, vblnk;
   logic [1:0]  game_active;
   logic        restart, frame_tick, hold_active;

   int vectors = 0;
   int miscompares = 0;
   int restart_cnt = 0;
   int tick_cnt = 0;
   int ga_at_tick, ga_after, rs_after, ha_after, ft_after;
   int snap;

   game_state_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .mouse_x       (mouse_x),
      .mouse_y       (mouse_y),
      .mouse_clicked (mouse_clicked),
      .char_class    (char_class),
      .player_dead   (player_dead),
      .boss_dead     (boss_dead),
      .vblnk         (vblnk),
      .game_active   (game_active),
      .restart       (restart),
      .frame_tick    (frame_tick),
      .hold_active   (hold_active)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (restart)    restart_cnt <= restart_cnt + 1;
      if (frame_tick) tick_cnt    <= tick_cnt + 1;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // raise vblnk, capture state during and after the tick cycle, then drop vblnk
   task automatic frame();
      int n;
      n = 0;
      vblnk = 1'b1;
      @(negedge clk);
      n++;
      while (!frame_tick && n < 6) begin
         @(negedge clk);
         n++;
      end
      if (!frame_tick) chk("tick_timeout", 0, 1);
      ga_at_tick = game_active;
      @(negedge clk);
      ga_after = game_active;
      rs_after = restart;
      ha_after = hold_active;
      ft_after = frame_tick;
      vblnk = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) frame();
   endtask

   task automatic click(input int x, input int y);
      mouse_x = 12'(x);
      mouse_y = 12'(y);
      mouse_clicked = 1'b1;
      repeat (2) @(negedge clk);
      mouse_clicked = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      mouse_x = '0; mouse_y = '0; mouse_clicked = 1'b0;
      char_class = 2'd0; player_dead = 1'b0; boss_dead = 1'b0;
      vblnk = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_game_active", game_active, 0);
      chk("rst_restart", restart, 0);
      chk("rst_frame_tick", frame_tick, 0);
      chk("rst_hold_active", hold_active, 0);

      // vblnk high through reset must not tick
      rst = 1'b0;
      snap = tick_cnt;
      repeat (5) @(negedge clk);
      chk("no_tick_vblnk_high_after_rst", tick_cnt - snap, 0);
      vblnk = 1'b0;
      repeat (3) @(negedge clk);

      // no class selected: click ignored
      click(400, 300);
      frames(2);
      chk("no_class_stays_select", ga_after, 0);

      // boundary clicks just outside the button
      char_class = 2'd1;
      click(299, 300);
      frame();
      chk("x_below_button", ga_after, 0);
      click(500, 300);
      frame();
      chk("x_at_right_edge", ga_after, 0);
      click(400, 325);
      frame();
      chk("y_at_bottom_edge", ga_after, 0);

      // valid start click mid-frame
      click(400, 300);
      chk("select_before_tick", game_active, 0);
      frame();
      chk("select_during_tick", ga_at_tick, 0);
      chk("play_after_tick", ga_after, 1);
      chk("tick_one_cycle", ft_after, 0);
      chk("no_restart_on_start", rs_after, 0);

      // both deaths together with the tick: lose wins
      player_dead = 1'b1;
      boss_dead = 1'b1;
      frame();
      chk("lose_priority", ga_after, 3);
      chk("hold_on_lose", ha_after, 1);
      player_dead = 1'b0;
      boss_dead = 1'b0;

      // click during hold ignored
      frames(49);
      click(10, 10);
      frame();
      chk("click_in_hold_ignored", ga_after, 3);
      frames(129);
      chk("hold_after_179", ha_after, 1);
      frame();
      chk("hold_after_180", ha_after, 0);
      frame();
      chk("no_return_without_click", ga_after, 3);

      snap = restart_cnt;
      click(10, 10);
      frame();
      chk("lose_during_tick", ga_at_tick, 3);
      chk("return_to_select", ga_after, 0);
      chk("restart_coincident", rs_after, 1);
      chk("restart_one_cycle", restart_cnt - snap, 1);

      // held button: one edge only, taken while class was 0
      char_class = 2'd0;
      mouse_x = 12'd400;
      mouse_y = 12'd300;
      mouse_clicked = 1'b1;
      repeat (2) @(negedge clk);
      char_class = 2'd2;
      frames(3);
      chk("held_click_no_repeat", ga_after, 0);
      mouse_clicked = 1'b0;
      repeat (2) @(negedge clk);
      click(400, 300);
      frame();
      chk("second_press_starts", ga_after, 1);
      frames(2);
      chk("play_stable", ga_after, 1);

      // win pending first blocks a later death
      boss_dead = 1'b1;
      repeat (2) @(negedge clk);
      player_dead = 1'b1;
      repeat (2) @(negedge clk);
      frame();
      chk("win_pending_blocks_lose", ga_after, 2);
      chk("hold_on_win", ha_after, 1);
      boss_dead = 1'b0;
      player_dead = 1'b0;

      // reset mid-hold
      frames(90);
      chk("hold_mid_win", hold_active, 1);
      snap = restart_cnt;
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_hold_state", game_active, 0);
      chk("rst_mid_hold_hold", hold_active, 0);
      chk("rst_mid_hold_restart", restart, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_no_restart_pulse", restart_cnt - snap, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
